pipe_stage_reg: RTL

//   Parametrised pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_slot.sv | 31 +++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and slot-load selector for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned PIPE_PERF_W = 32;

    typedef enum logic [1:0] {
        SEL_IN   = 2'd0,
        SEL_SKID = 2'd1,
        SEL_HOLD = 2'd2
    } slot_sel_e;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, data} holding register with load, drop and clear (reset/flush).
module pipe_slot #(
    parameter int unsigned WIDTH      = 64,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Clear beats load beats drop; payload is only zeroed when CLEAR_DATA is set.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            if (CLEAR_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter port enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] stall_cycles
`endif
);

    logic             m_v;
    logic             s_v;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_d;

    logic             acc_c;
    logic             pop_c;
    slot_sel_e        main_sel_c;
    logic             main_load_c;
    logic             main_drop_c;
    logic [WIDTH-1:0] main_load_data_c;
    logic             skid_load_c;
    logic             skid_drop_c;

    assign in_ready  = !s_v;
    assign out_valid = m_v;
    assign out_data  = m_d;

    assign acc_c = in_valid && in_ready;
    assign pop_c = m_v && out_ready;

    // Slot update selection; skid only fills when main is held, and drains first on pop.
    always_comb begin
        main_sel_c  = SEL_HOLD;
        main_drop_c = 1'b0;
        skid_load_c = 1'b0;
        skid_drop_c = 1'b0;
        if (pop_c && s_v) begin
            main_sel_c  = SEL_SKID;
            skid_drop_c = 1'b1;
        end else if (pop_c) begin
            if (acc_c) begin
                main_sel_c = SEL_IN;
            end else begin
                main_drop_c = 1'b1;
            end
        end else if (acc_c) begin
            if (!m_v) begin
                main_sel_c = SEL_IN;
            end else begin
                skid_load_c = 1'b1;
            end
        end
    end

    assign main_load_c      = (main_sel_c != SEL_HOLD);
    assign main_load_data_c = (main_sel_c == SEL_SKID) ? s_d : in_data;

    pipe_slot #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (main_load_c),
        .drop      (main_drop_c),
        .load_data (main_load_data_c),
        .valid     (m_v),
        .data      (m_d)
    );

    pipe_slot #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (skid_load_c),
        .drop      (skid_drop_c),
        .load_data (in_data),
        .valid     (s_v),
        .data      (s_d)
    );

`ifdef PIPE_STAGE_PERF_EN
    // Saturating count of cycles the downstream stage holds off a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (m_v && !out_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PIPE_PERF_W'(1);
        end
    end
`endif

    // A filled skid slot always sits behind a filled main slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!s_v || m_v);
        end
    end

endmodule
